// File: rtl/counter_pingpong_ctrl.sv
// counter_pingpong_ctrl
// Sequences an external up/down loadable counter so that it bounces between
// two turn-around values. A run loads a start value, counts up to the upper
// value, back down to the lower value, and repeats. One round is credited
// each time the counter turns around at the lower value. The run ends on an
// abort request or, when a round limit is configured, after that many rounds.

module counter_pingpong_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             u_d,
  output logic             busy,
  output logic [WIDTH-1:0] rounds,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  // Round limit as a WIDTH-bit value so it can be compared with the
  // wrapping round counter. A limit of zero disables auto-stop entirely.
  localparam logic [WIDTH-1:0] ROUNDS_LIMIT = WIDTH'(ROUNDS);
  localparam logic [WIDTH-1:0] ROUND_STEP   = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rounds_q, rounds_d;
  logic [WIDTH-1:0] hi_r_q, hi_r_d;
  logic [WIDTH-1:0] lo_r_q, lo_r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cfg_valid;
  logic [WIDTH-1:0] rounds_inc;

  // A configuration is usable only if the window is non-empty and the start
  // value lies inside it (inclusive at both ends).
  assign cfg_valid  = (cfg_lo < cfg_hi) && (cfg_start >= cfg_lo) && (cfg_start <= cfg_hi);
  assign rounds_inc = rounds_q + ROUND_STEP;

  // Next-state and next-output computation; stop while busy overrides every
  // other transition, and start is only honoured from IDLE without stop.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rounds_d = rounds_q;
    hi_r_d   = hi_r_q;
    lo_r_d   = lo_r_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            if (cfg_valid) begin
              state_d  = S_LOAD;
              data_d   = cfg_start;
              hi_r_d   = cfg_hi;
              lo_r_d   = cfg_lo;
              rounds_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_d = S_UP;
        end
        S_UP: begin
          if (count == hi_r_q) begin
            state_d = S_DOWN;
          end
        end
        S_DOWN: begin
          if (count == lo_r_q) begin
            rounds_d = rounds_inc;
            if ((ROUNDS != 0) && (rounds_inc == ROUNDS_LIMIT)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_UP;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register all FSM state, the latched configuration and the pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      rounds_q <= '0;
      hi_r_q   <= '0;
      lo_r_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rounds_q <= rounds_d;
      hi_r_q   <= hi_r_d;
      lo_r_q   <= lo_r_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Direction is chosen one step ahead so the counter turns exactly at the
  // latched limits instead of overshooting them.
  always_comb begin
    u_d = 1'b1;
    case (state_q)
      S_UP:    u_d = (count != hi_r_q);
      S_DOWN:  u_d = (count == lo_r_q);
      default: u_d = 1'b1;
    endcase
  end

  assign load   = (state_q == S_LOAD);
  assign busy   = (state_q != S_IDLE);
  assign data   = data_q;
  assign rounds = rounds_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_counter_pingpong_ctrl.sv
// tb_counter_pingpong_ctrl
// Directed bench for counter_pingpong_ctrl. Instance a uses ROUNDS=2 and
// instance b uses ROUNDS=0. Each instance drives its own model of the
// downstream loadable up/down counter.

module tb_counter_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_start = 8'd0;
  logic [7:0] cfg_hi = 8'd0;
  logic [7:0] cfg_lo = 8'd0;

  logic       a_load, a_u_d, a_busy, a_done, a_err;
  logic [7:0] a_data, a_rounds, cnt_a;
  logic       b_load, b_u_d, b_busy, b_done, b_err;
  logic [7:0] b_data, b_rounds, cnt_b;

  int total = 0;
  int bad = 0;

  // Expected counter values for start=5, lo=3, hi=8 over two rounds
  logic [7:0] seq_a [19] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3,
                             8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};

  counter_pingpong_ctrl #(.WIDTH(8), .ROUNDS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_start(cfg_start), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .count(cnt_a),
    .load(a_load), .data(a_data), .u_d(a_u_d), .busy(a_busy),
    .rounds(a_rounds), .done(a_done), .err(a_err)
  );

  counter_pingpong_ctrl #(.WIDTH(8), .ROUNDS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_start(cfg_start), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .count(cnt_b),
    .load(b_load), .data(b_data), .u_d(b_u_d), .busy(b_busy),
    .rounds(b_rounds), .done(b_done), .err(b_err)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Downstream counter model for instance a
  always @(posedge clk or negedge rst) begin
    if (!rst)        cnt_a <= 8'd0;
    else if (a_load) cnt_a <= a_data;
    else if (a_busy) cnt_a <= a_u_d ? cnt_a + 8'd1 : cnt_a - 8'd1;
  end

  // Downstream counter model for instance b
  always @(posedge clk or negedge rst) begin
    if (!rst)        cnt_b <= 8'd0;
    else if (b_load) cnt_b <= b_data;
    else if (b_busy) cnt_b <= b_u_d ? cnt_b + 8'd1 : cnt_b - 8'd1;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, want the sequence to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (a_busy !== 1'b0 || a_load !== 1'b0 || a_data !== 8'd0 || a_rounds !== 8'd0 ||
        a_done !== 1'b0 || a_err !== 1'b0 || a_u_d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_a: busy=%b load=%b data=%0d rounds=%0d done=%b err=%b u_d=%b, want 0 0 0 0 0 0 1",
               a_busy, a_load, a_data, a_rounds, a_done, a_err, a_u_d);
    end
    total++;
    if (b_busy !== 1'b0 || b_load !== 1'b0 || b_data !== 8'd0 || b_rounds !== 8'd0 ||
        b_done !== 1'b0 || b_err !== 1'b0 || b_u_d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_b: busy=%b load=%b data=%0d rounds=%0d done=%b err=%b u_d=%b, want 0 0 0 0 0 0 1",
               b_busy, b_load, b_data, b_rounds, b_done, b_err, b_u_d);
    end
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (a_busy !== 1'b0 || a_load !== 1'b0 || a_u_d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release: busy=%b load=%b u_d=%b, want 0 0 1", a_busy, a_load, a_u_d);
    end
  endtask

  task automatic test_basic;
    int loads;
    logic exp_ud;
    do_reset();
    cfg_start = 8'd5; cfg_lo = 8'd3; cfg_hi = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (a_load !== 1'b1 || a_data !== 8'd5 || a_u_d !== 1'b1 || a_busy !== 1'b1 || a_rounds !== 8'd0) begin
      bad++;
      $display("[TB] FAIL basic_load: load=%b data=%0d u_d=%b busy=%b rounds=%0d, want 1 5 1 1 0",
               a_load, a_data, a_u_d, a_busy, a_rounds);
    end
    loads = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (a_load === 1'b1) loads++;
      exp_ud = (i < 18) ? (seq_a[i+1] > seq_a[i]) : 1'b1;
      total++;
      if (cnt_a !== seq_a[i] || a_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL basic_seq[%0d]: count=%0d busy=%b, want %0d 1", i, cnt_a, a_busy, seq_a[i]);
      end
      total++;
      if (a_u_d !== exp_ud) begin
        bad++;
        $display("[TB] FAIL basic_ud[%0d]: u_d=%b, want %b", i, a_u_d, exp_ud);
      end
      total++;
      if (a_rounds !== ((i >= 9) ? 8'd1 : 8'd0)) begin
        bad++;
        $display("[TB] FAIL basic_rounds[%0d]: rounds=%0d, want %0d", i, a_rounds, (i >= 9) ? 1 : 0);
      end
    end
    total++;
    if (loads != 0) begin
      bad++;
      $display("[TB] FAIL basic_single_load: extra loads=%0d, want 0", loads);
    end
    tick();
    total++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_rounds !== 8'd2 || a_load !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done: done=%b busy=%b rounds=%0d load=%b, want 1 0 2 0",
               a_done, a_busy, a_rounds, a_load);
    end
    tick();
    total++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || a_rounds !== 8'd2) begin
      bad++;
      $display("[TB] FAIL basic_done_pulse: done=%b busy=%b rounds=%0d, want 0 0 2", a_done, a_busy, a_rounds);
    end
  endtask

  task automatic test_invalid;
    logic [7:0] inv_s  [4] = '{8'd5, 8'd5, 8'd9, 8'd2};
    logic [7:0] inv_lo [4] = '{8'd9, 8'd5, 8'd3, 8'd3};
    logic [7:0] inv_hi [4] = '{8'd4, 8'd5, 8'd8, 8'd8};
    for (int k = 0; k < 4; k++) begin
      cfg_start = inv_s[k]; cfg_lo = inv_lo[k]; cfg_hi = inv_hi[k]; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (a_err !== 1'b1 || a_busy !== 1'b0 || a_load !== 1'b0 || a_rounds !== 8'd2) begin
        bad++;
        $display("[TB] FAIL invalid_err[%0d]: err=%b busy=%b load=%b rounds=%0d, want 1 0 0 2",
                 k, a_err, a_busy, a_load, a_rounds);
      end
      tick();
      total++;
      if (a_err !== 1'b0 || a_busy !== 1'b0 || a_load !== 1'b0) begin
        bad++;
        $display("[TB] FAIL invalid_pulse[%0d]: err=%b busy=%b load=%b, want 0 0 0", k, a_err, a_busy, a_load);
      end
    end
  endtask

  task automatic test_start_at_hi;
    do_reset();
    cfg_start = 8'd10; cfg_lo = 8'd2; cfg_hi = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (a_load !== 1'b1 || a_data !== 8'd10) begin
      bad++;
      $display("[TB] FAIL hi_load: load=%b data=%0d, want 1 10", a_load, a_data);
    end
    tick();
    total++;
    if (cnt_a !== 8'd10 || a_u_d !== 1'b0 || a_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hi_turn: count=%0d u_d=%b busy=%b, want 10 0 1", cnt_a, a_u_d, a_busy);
    end
    tick();
    total++;
    if (cnt_a !== 8'd9 || a_u_d !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hi_first_dec: count=%0d u_d=%b, want 9 0", cnt_a, a_u_d);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_load !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hi_stop: busy=%b done=%b load=%b, want 0 0 0", a_busy, a_done, a_load);
    end
  endtask

  task automatic test_start_at_lo;
    do_reset();
    cfg_start = 8'd2; cfg_lo = 8'd2; cfg_hi = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (cnt_a !== 8'd2 || a_u_d !== 1'b1 || a_rounds !== 8'd0) begin
      bad++;
      $display("[TB] FAIL lo_first: count=%0d u_d=%b rounds=%0d, want 2 1 0", cnt_a, a_u_d, a_rounds);
    end
    tick();
    total++;
    if (cnt_a !== 8'd3 || a_rounds !== 8'd0) begin
      bad++;
      $display("[TB] FAIL lo_no_credit: count=%0d rounds=%0d, want 3 0", cnt_a, a_rounds);
    end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (cnt_a !== 8'd2 || a_u_d !== 1'b1 || a_rounds !== 8'd0) begin
      bad++;
      $display("[TB] FAIL lo_bottom: count=%0d u_d=%b rounds=%0d, want 2 1 0", cnt_a, a_u_d, a_rounds);
    end
    tick();
    total++;
    if (cnt_a !== 8'd3 || a_rounds !== 8'd1 || a_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lo_credit: count=%0d rounds=%0d busy=%b, want 3 1 1", cnt_a, a_rounds, a_busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_stop_sweep;
    int hit;
    int jumps;
    logic [7:0] prev;
    do_reset();
    cfg_start = 8'd0; cfg_lo = 8'd0; cfg_hi = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    jumps = 0;
    prev = 8'd0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      if (n >= 2 && int'(cnt_b) != int'(prev) + 1 && int'(cnt_b) != int'(prev) - 1) jumps++;
      if (b_busy !== 1'b1) jumps++;
      prev = cnt_b;
      if (b_rounds === 8'd3) begin
        hit = n;
        break;
      end
    end
    total++;
    if (hit != 1532) begin
      bad++;
      $display("[TB] FAIL sweep_round3_cycle: cycle=%0d, want 1532", hit);
    end
    total++;
    if (jumps != 0) begin
      bad++;
      $display("[TB] FAIL sweep_no_wrap: bad steps=%0d, want 0", jumps);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (b_busy !== 1'b0 || b_rounds !== 8'd3 || b_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sweep_stop: busy=%b rounds=%0d done=%b, want 0 3 0", b_busy, b_rounds, b_done);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if (b_busy !== 1'b0 || b_err !== 1'b0 || b_load !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_start_idle: busy=%b err=%b load=%b, want 0 0 0", b_busy, b_err, b_load);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    cfg_start = 8'd5; cfg_lo = 8'd3; cfg_hi = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    total++;
    if (cnt_a !== 8'd6 || a_rounds !== 8'd1 || a_u_d !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_pre: count=%0d rounds=%0d u_d=%b, want 6 1 0", cnt_a, a_rounds, a_u_d);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (a_busy !== 1'b0 || a_load !== 1'b0 || a_data !== 8'd0 || a_rounds !== 8'd0 ||
        a_done !== 1'b0 || a_err !== 1'b0 || a_u_d !== 1'b1) begin
      bad++;
      $display("[TB] FAIL areset_now: busy=%b load=%b data=%0d rounds=%0d done=%b err=%b u_d=%b, want 0 0 0 0 0 0 1",
               a_busy, a_load, a_data, a_rounds, a_done, a_err, a_u_d);
    end
    tick();
    total++;
    if (a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_no_pulse: done=%b err=%b busy=%b, want 0 0 0", a_done, a_err, a_busy);
    end
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (a_load !== 1'b1 || a_data !== 8'd5) begin
      bad++;
      $display("[TB] FAIL areset_restart: load=%b data=%0d, want 1 5", a_load, a_data);
    end
    for (int i = 0; i < 19; i++) begin
      tick();
      total++;
      if (cnt_a !== seq_a[i]) begin
        bad++;
        $display("[TB] FAIL areset_seq[%0d]: count=%0d, want %0d", i, cnt_a, seq_a[i]);
      end
    end
    tick();
    total++;
    if (a_done !== 1'b1 || a_rounds !== 8'd2 || a_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_done: done=%b rounds=%0d busy=%b, want 1 2 0", a_done, a_rounds, a_busy);
    end
  endtask

  task automatic test_back_to_back;
    int loads;
    do_reset();
    cfg_start = 8'd5; cfg_lo = 8'd3; cfg_hi = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_start = 8'd1; cfg_lo = 8'd0; cfg_hi = 8'd20;
    loads = 0;
    for (int i = 0; i < 19; i++) begin
      start = (i % 2 == 0) && (i < 18);
      tick();
      if (a_load === 1'b1) loads++;
      total++;
      if (cnt_a !== seq_a[i] || a_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midrun_seq[%0d]: count=%0d err=%b, want %0d 0", i, cnt_a, a_err, seq_a[i]);
      end
    end
    start = 1'b0;
    total++;
    if (loads != 0) begin
      bad++;
      $display("[TB] FAIL midrun_reload: extra loads=%0d, want 0", loads);
    end
    tick();
    total++;
    if (a_done !== 1'b1 || a_rounds !== 8'd2 || a_data !== 8'd5) begin
      bad++;
      $display("[TB] FAIL midrun_done: done=%b rounds=%0d data=%0d, want 1 2 5", a_done, a_rounds, a_data);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] counter_pingpong_ctrl bench start");
    test_reset();
    test_basic();
    test_invalid();
    test_start_at_hi();
    test_start_at_lo();
    test_stop_sweep();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
